// File: rtl/mips_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the FSM state type, opcode/funct encodings and the ALU select codes.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps aluop and the R-type funct field to the 4-bit ALU select.
// valid reports whether funct is a supported R-type function, independent of aluop.
module aludec
   import mips_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [3:0] alucontrol,
   output logic       valid
);

   logic [3:0] funct_alu;

   always_comb begin
      valid     = 1'b1;
      funct_alu = ALU_ADD;
      case (funct)
         FUNCT_ADD: funct_alu = ALU_ADD;
         FUNCT_SUB: funct_alu = ALU_SUB;
         FUNCT_AND: funct_alu = ALU_AND;
         FUNCT_OR:  funct_alu = ALU_OR;
         FUNCT_SLT: funct_alu = ALU_SLT;
         default:   valid     = 1'b0;
      endcase
   end

   always_comb begin
      case (aluop)
         ALUOP_ADD:   alucontrol = ALU_ADD;
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: alucontrol = funct_alu;
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath strobes, mux selects
// and the ALU select for each FETCH/DECODE/execute step of an instruction.
module mc_controller
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       regwrite,
   output logic       memwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [3:0] alucontrol,
   output logic       illegal
);

   state_t state_q, state_d;
   state_t out_state;
   aluop_t aluop;
   logic   funct_valid;
   logic   pcwrite, branch;
   logic   irwrite_s, regwrite_s, memwrite_s, illegal_s;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol),
      .valid      (funct_valid)
   );

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = funct_valid ? S_EXEC : S_FETCH;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase
   end

   // During reset the muxes present the FETCH settings; strobes are gated below.
   assign out_state = reset ? S_FETCH : state_q;

   always_comb begin
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      illegal_s  = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      case (out_state)
         S_FETCH: begin
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = 2'b01;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_s = 1'b0;
               OP_RTYPE: illegal_s = ~funct_valid;
               default:  illegal_s = 1'b1;
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            branch  = 1'b1;
            pcsrc   = 2'b01;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         S_ADDIWB: regwrite_s = 1'b1;
         S_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'b10;
         end
         default: ;
      endcase
   end

   assign pcen     = ~reset & (pcwrite | (branch & zero));
   assign irwrite  = ~reset & irwrite_s;
   assign regwrite = ~reset & regwrite_s;
   assign memwrite = ~reset & memwrite_s;
   assign illegal  = ~reset & illegal_s;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues the expected output word
// for each cycle, a negedge monitor pops and compares against the DUT.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;
   logic       pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [3:0] alucontrol;
   logic       illegal;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [16:0] v;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   mc_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .irwrite    (irwrite),
      .regwrite   (regwrite),
      .memwrite   (memwrite),
      .iord       (iord),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol),
      .illegal    (illegal)
   );

   // Field order: pcen irwrite regwrite memwrite iord memtoreg regdst alusrca
   //              alusrcb pcsrc alucontrol illegal
   localparam logic [16:0] E_RESET  = 17'b0_0_0_0_0_0_0_0_01_00_0010_0;
   localparam logic [16:0] E_FETCH  = 17'b1_1_0_0_0_0_0_0_01_00_0010_0;
   localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_11_00_0010_0;
   localparam logic [16:0] E_DEC_IL = 17'b0_0_0_0_0_0_0_0_11_00_0010_1;
   localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_1_10_00_0010_0;
   localparam logic [16:0] E_MEMRD  = 17'b0_0_0_0_1_0_0_0_00_00_0010_0;
   localparam logic [16:0] E_MEMWB  = 17'b0_0_1_0_0_1_0_0_00_00_0010_0;
   localparam logic [16:0] E_MEMWR  = 17'b0_0_0_1_1_0_0_0_00_00_0010_0;
   localparam logic [16:0] E_EX_ADD = 17'b0_0_0_0_0_0_0_1_00_00_0010_0;
   localparam logic [16:0] E_EX_SUB = 17'b0_0_0_0_0_0_0_1_00_00_0110_0;
   localparam logic [16:0] E_EX_AND = 17'b0_0_0_0_0_0_0_1_00_00_0000_0;
   localparam logic [16:0] E_EX_OR  = 17'b0_0_0_0_0_0_0_1_00_00_0001_0;
   localparam logic [16:0] E_EX_SLT = 17'b0_0_0_0_0_0_0_1_00_00_0111_0;
   localparam logic [16:0] E_ALUWB  = 17'b0_0_1_0_0_0_1_0_00_00_0010_0;
   localparam logic [16:0] E_BR_Z1  = 17'b1_0_0_0_0_0_0_1_00_01_0110_0;
   localparam logic [16:0] E_BR_Z0  = 17'b0_0_0_0_0_0_0_1_00_01_0110_0;
   localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_1_10_00_0010_0;
   localparam logic [16:0] E_ADDIWB = 17'b0_0_1_0_0_0_0_0_00_00_0010_0;
   localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_00_10_0010_0;

   // Drive one cycle's inputs just after the edge and queue that cycle's expectation.
   task automatic cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [16:0] e, input string n);
      @(posedge clk);
      #1;
      reset = r;
      op    = o;
      funct = f;
      zero  = z;
      exp_q.push_back('{v: e, name: n});
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [16:0] got;
         e   = exp_q.pop_front();
         got = {pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal};
         checks++;
         if (got !== e.v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", e.name, got, e.v);
         end
      end
   end

   initial begin
      cyc(1'b1, 6'd0, 6'd0, 1'b0, E_RESET, "reset");
      cyc(1'b1, 6'd0, 6'd0, 1'b0, E_RESET, "reset_hold");

      $display("txn lw");
      cyc(1'b0, 6'b100011, 6'd0, 1'b0, E_FETCH,  "lw_fetch");
      cyc(1'b0, 6'b100011, 6'd0, 1'b0, E_DECODE, "lw_decode");
      cyc(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMADR, "lw_memadr");
      cyc(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMRD,  "lw_memrd");
      cyc(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMWB,  "lw_memwb");

      $display("txn sw");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_FETCH,  "sw_fetch");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_DECODE, "sw_decode");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_MEMADR, "sw_memadr");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_MEMWR,  "sw_memwr");

      $display("txn r_sub");
      cyc(1'b0, 6'b000000, 6'b100010, 1'b0, E_FETCH,  "sub_fetch");
      cyc(1'b0, 6'b000000, 6'b100010, 1'b0, E_DECODE, "sub_decode");
      cyc(1'b0, 6'b000000, 6'b100010, 1'b0, E_EX_SUB, "sub_exec");
      cyc(1'b0, 6'b000000, 6'b100010, 1'b0, E_ALUWB,  "sub_aluwb");

      $display("txn r_slt/and/or/add");
      cyc(1'b0, 6'b000000, 6'b101010, 1'b0, E_FETCH,  "slt_fetch");
      cyc(1'b0, 6'b000000, 6'b101010, 1'b0, E_DECODE, "slt_decode");
      cyc(1'b0, 6'b000000, 6'b101010, 1'b0, E_EX_SLT, "slt_exec");
      cyc(1'b0, 6'b000000, 6'b101010, 1'b0, E_ALUWB,  "slt_aluwb");
      cyc(1'b0, 6'b000000, 6'b100100, 1'b0, E_FETCH,  "and_fetch");
      cyc(1'b0, 6'b000000, 6'b100100, 1'b0, E_DECODE, "and_decode");
      cyc(1'b0, 6'b000000, 6'b100100, 1'b0, E_EX_AND, "and_exec");
      cyc(1'b0, 6'b000000, 6'b100100, 1'b0, E_ALUWB,  "and_aluwb");
      cyc(1'b0, 6'b000000, 6'b100101, 1'b0, E_FETCH,  "or_fetch");
      cyc(1'b0, 6'b000000, 6'b100101, 1'b0, E_DECODE, "or_decode");
      cyc(1'b0, 6'b000000, 6'b100101, 1'b0, E_EX_OR,  "or_exec");
      cyc(1'b0, 6'b000000, 6'b100101, 1'b0, E_ALUWB,  "or_aluwb");
      cyc(1'b0, 6'b000000, 6'b100000, 1'b0, E_FETCH,  "add_fetch");
      cyc(1'b0, 6'b000000, 6'b100000, 1'b0, E_DECODE, "add_decode");
      cyc(1'b0, 6'b000000, 6'b100000, 1'b0, E_EX_ADD, "add_exec");
      cyc(1'b0, 6'b000000, 6'b100000, 1'b0, E_ALUWB,  "add_aluwb");

      $display("txn addi");
      cyc(1'b0, 6'b001000, 6'd0, 1'b0, E_FETCH,  "addi_fetch");
      cyc(1'b0, 6'b001000, 6'd0, 1'b0, E_DECODE, "addi_decode");
      cyc(1'b0, 6'b001000, 6'd0, 1'b0, E_ADDIEX, "addi_ex");
      cyc(1'b0, 6'b001000, 6'd0, 1'b0, E_ADDIWB, "addi_wb");

      $display("txn beq taken");
      cyc(1'b0, 6'b000100, 6'd0, 1'b1, E_FETCH,  "beq1_fetch");
      cyc(1'b0, 6'b000100, 6'd0, 1'b1, E_DECODE, "beq1_decode");
      cyc(1'b0, 6'b000100, 6'd0, 1'b1, E_BR_Z1,  "beq1_branch");

      $display("txn beq not taken");
      cyc(1'b0, 6'b000100, 6'd0, 1'b0, E_FETCH,  "beq0_fetch");
      cyc(1'b0, 6'b000100, 6'd0, 1'b0, E_DECODE, "beq0_decode");
      cyc(1'b0, 6'b000100, 6'd0, 1'b0, E_BR_Z0,  "beq0_branch");

      $display("txn j");
      cyc(1'b0, 6'b000010, 6'd0, 1'b0, E_FETCH,  "j_fetch");
      cyc(1'b0, 6'b000010, 6'd0, 1'b0, E_DECODE, "j_decode");
      cyc(1'b0, 6'b000010, 6'd0, 1'b0, E_JUMP,   "j_jump");

      $display("txn illegal op");
      cyc(1'b0, 6'b111111, 6'd0, 1'b0, E_FETCH,  "ill_fetch");
      cyc(1'b0, 6'b111111, 6'd0, 1'b0, E_DEC_IL, "ill_decode");

      $display("txn illegal funct");
      cyc(1'b0, 6'b000000, 6'b000000, 1'b0, E_FETCH,  "illf_fetch");
      cyc(1'b0, 6'b000000, 6'b000000, 1'b0, E_DEC_IL, "illf_decode");

      $display("txn sw aborted by reset");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_FETCH,  "swr_fetch");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_DECODE, "swr_decode");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_MEMADR, "swr_memadr");
      cyc(1'b1, 6'b101011, 6'd0, 1'b0, E_RESET,  "swr_reset_in_memwr");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_FETCH,  "swr_refetch");
      cyc(1'b0, 6'b101011, 6'd0, 1'b0, E_DECODE, "swr_redecode");

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
